// File: rtl/trap_dump_unit.sv
// rtl/trap_dump_unit.sv - trap-triggered DMEM window dump streamed as big-endian words
//
// Watches the fetch stream for TRAP_WORD; on a valid match it halts the
// pipeline, reads DUMP_WORDS words (byte by byte) starting at DUMP_BASE over
// the DMEM debug port and streams them out over a valid/ready interface.
//
// Optional build macro: TRAP_DUMP_CHECKSUM_EN appends one word holding the
// 32-bit sum of all dumped words; dump_last then marks only that word.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   instr, instr_valid  instruction in fetch and its qualifier
//   halt                freezes PC and pipeline registers
//   dmem_rd_en          DMEM debug read strobe
//   dmem_addr           DMEM byte address
//   dmem_rdata          read byte, one cycle after dmem_rd_en
//   dump_valid          dump_data/dump_addr/dump_last valid
//   dump_ready          consumer accepts the word
//   dump_data           assembled word, lowest address in bits 31:24
//   dump_addr           byte address of the word
//   dump_last           final word of the dump
//   done                dump complete, sticky until reset
module trap_dump_unit #(
    parameter logic [31:0] TRAP_WORD  = 32'h44000300,
    parameter int unsigned DUMP_BASE  = 8192,
    parameter int unsigned DUMP_WORDS = 10,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              halt,
    output logic              dmem_rd_en,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [7:0]        dmem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(4);
    localparam logic [7:0]        LAST_W = 8'(DUMP_WORDS - 1);

    state_t            state;
    logic [7:0]        w;      // word counter
    logic [2:0]        b;      // byte counter within READ
    logic [23:0]       sr;     // first three bytes of the word being assembled
    logic [ADDR_W-1:0] waddr;  // byte address of the current word
`ifdef TRAP_DUMP_CHECKSUM_EN
    logic [31:0]       csum;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            halt       <= 1'b0;
            dmem_rd_en <= 1'b0;
            dmem_addr  <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
            w          <= '0;
            b          <= '0;
            sr         <= '0;
            waddr      <= '0;
`ifdef TRAP_DUMP_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr == TRAP_WORD) begin
                        halt       <= 1'b1;
                        w          <= '0;
                        b          <= '0;
                        waddr      <= BASE_A;
                        dmem_addr  <= BASE_A;
                        dmem_rd_en <= 1'b1;
`ifdef TRAP_DUMP_CHECKSUM_EN
                        csum       <= '0;
`endif
                        state      <= READ;
                    end
                end
                READ: begin
                    // rdata lags the strobe by one cycle, so the byte read
                    // at b-1 arrives during b.
                    if (b != 3'd0)
                        sr <= {sr[15:0], dmem_rdata};
                    if (b < 3'd3)
                        dmem_addr <= dmem_addr + ONE_A;
                    if (b == 3'd3)
                        dmem_rd_en <= 1'b0;
                    if (b == 3'd4) begin
                        dump_data  <= {sr, dmem_rdata};
                        dump_addr  <= waddr;
                        dump_valid <= 1'b1;
`ifdef TRAP_DUMP_CHECKSUM_EN
                        csum       <= csum + {sr, dmem_rdata};
                        dump_last  <= 1'b0;
`else
                        dump_last  <= (w == LAST_W);
`endif
                        state      <= SEND;
                    end else begin
                        b <= b + 3'd1;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        if (dump_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
`ifdef TRAP_DUMP_CHECKSUM_EN
                        else if (w == LAST_W) begin
                            // Checksum word goes out immediately, no reads.
                            dump_valid <= 1'b1;
                            dump_data  <= csum;
                            dump_addr  <= waddr + STEP_A;
                            dump_last  <= 1'b1;
                        end
`endif
                        else begin
                            w          <= w + 8'd1;
                            b          <= '0;
                            waddr      <= waddr + STEP_A;
                            dmem_addr  <= waddr + STEP_A;
                            dmem_rd_en <= 1'b1;
                            state      <= READ;
                        end
                    end
                end
                DONE: begin
                    halt <= 1'b1;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/trap_dump_unit.md
Name: trap_dump_unit

Overview:
- Hardware end of the end-of-program memory dump.
- Watches the fetched instruction stream for the trap word (trap 0x300). On a match it freezes the pipeline and walks a fixed DMEM window byte by byte.
- Assembles each group of four bytes into a big-endian 32-bit word and streams the words out over a valid/ready interface.
- Sits beside the pipeline top level, sharing the DMEM debug read port.

Parameters:
- TRAP_WORD, 32'h44000300, instruction encoding that triggers the dump
- DUMP_BASE, 8192, first DMEM byte address dumped; must be a multiple of 4
- DUMP_WORDS, 10, number of 32-bit words dumped; legal range 1..255
- ADDR_W, 32, DMEM address width

Ports:
- clock  in  1  system clock, all state on the rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction currently in fetch
- instr_valid  in  1  instr is a real fetched instruction, not a bubble
- halt  out  1  freezes PC and pipeline registers
- dmem_rd_en  out  1  DMEM debug read strobe
- dmem_addr  out  ADDR_W  DMEM byte address
- dmem_rdata  in  8  read byte, valid exactly one cycle after dmem_rd_en
- dump_valid  out  1  dump_data/dump_addr are valid
- dump_ready  in  1  consumer accepts the word
- dump_data  out  32  assembled word, big-endian (lowest address = bits 31:24)
- dump_addr  out  ADDR_W  byte address of the word
- dump_last  out  1  final word of the dump
- done  out  1  dump complete; sticky until reset

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - halt, dmem_rd_en, dump_valid, dump_last and done go to 0.
  - dmem_addr, dump_data and dump_addr go to 0.
  - Word counter and byte counter are cleared.
- Reset asserted in any state aborts the dump immediately; no partial word is emitted.
- IDLE:
  - Leaves IDLE when instr_valid && instr == TRAP_WORD.
  - On that edge: halt=1, word counter w=0, move to READ. halt stays 1 in every state except IDLE.
- READ:
  - Lasts 5 cycles per word, with byte counter b running 0..4.
  - Cycles b=0..3: dmem_rd_en=1, dmem_addr = DUMP_BASE + 4*w + b.
  - Cycles b=1..4: capture dmem_rdata into the shift register, shifting left by 8.
  - Cycle b=4: dmem_rd_en=0. On the following edge load dump_data, set dump_addr = DUMP_BASE + 4*w, set dump_valid=1, set dump_last = (w == DUMP_WORDS-1), and move to SEND.
- SEND:
  - dump_data, dump_addr and dump_last stay stable while dump_valid && !dump_ready.
  - Transfer happens on the edge where dump_valid && dump_ready; dump_valid drops on that edge.
  - If dump_last was set: go to DONE.
  - Otherwise: w+1, b=0, go to READ.
  - dump_ready held high gives a transfer in the first SEND cycle, so the steady state is 6 cycles per word.
  - dump_ready is ignored outside SEND.
- DONE:
  - done=1 and halt=1. No further reads.
  - Stays in DONE until reset; traps are ignored here.
- Trap words seen while in READ, SEND or DONE are ignored; a dump never restarts.
- A trap with instr_valid=0 is ignored.
- Address arithmetic is modulo 2^ADDR_W. No range check beyond the parameter limits.
- Total latency from the trap edge to the first dump_valid is 6 cycles.

Optional Feature:
- Macro: TRAP_DUMP_CHECKSUM_EN.
- Defined:
  - After the last data word, one extra word is sent carrying the 32-bit sum (mod 2^32) of all dumped words, with dump_addr = DUMP_BASE + 4*DUMP_WORDS.
  - dump_last is asserted only on the checksum word.
  - The checksum word is presented on the edge after the last data word transfers; it needs no READ cycles.
- Undefined:
  - No checksum logic is built.
  - dump_last is asserted on data word DUMP_WORDS-1.

Test Plan:
- DMEM[8192..8195] = 00 00 01 2C, rest of window = 0, dump_ready tied 1, instr = 44000300 -> halt rises on the next edge; first dump_valid 6 cycles after the trap with dump_data=0000012C, dump_addr=8192; 10 words total; dump_last on dump_addr=8228; done=1.
- dump_ready low for 7 cycles during word 3 -> dump_data and dump_addr stay stable throughout; no word is lost or duplicated; sequence order unchanged.
- instr = 44000300 with instr_valid=0, then instr = 44000301 with instr_valid=1 -> halt stays 0 and dmem_rd_en never rises.
- Reset pulsed while in READ at word 4 -> all outputs 0 on the next edge; a later trap restarts from word 0 at 8192.
- Second trap while in SEND, and another while in DONE -> ignored; word count stays 10; done stays 1.
- TRAP_DUMP_CHECKSUM_EN defined, words 1..10 -> 11 transfers; the last has dump_data=0x37 (55), dump_addr=8232, dump_last=1.
